// File: rtl/warp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : warp_pkg
// Brief    : Shared warp lifecycle encoding and sizing helpers for the core.
// Revision : 1.0
// ============================================================================
package warp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READY    = 3'd1,
    SLOT     = 3'd2,
    INFLIGHT = 3'd3,
    DONE     = 3'd4
  } warp_state_t;

  // Width of a warp id; never below one bit so single-warp builds still elaborate.
  function automatic int warp_id_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/warp_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; first request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PTR_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic                valid
);

  logic [PTR_BITS-1:0] w_idx;

  // NUM_REQ is a power of two, so the index addition wraps naturally.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ptr + PTR_BITS'(i);
      if (!valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : warp_scheduler
// Brief    : Tracks per-warp PC/mask/lifecycle and issues ready warps
//            round-robin through a registered valid/ready slot.
// Revision : 1.0
// ============================================================================
module warp_scheduler
  import warp_pkg::*;
#(
  parameter  int NUM_WARPS             = 4,
  parameter  int PROGRAM_MEM_ADDR_BITS = 8,
  parameter  int THREADS_PER_BLOCK     = 4,
  localparam int WARP_ID_BITS          = warp_id_bits(NUM_WARPS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [WARP_ID_BITS-1:0]          issue_warp,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] issue_pc,
  output logic [THREADS_PER_BLOCK-1:0]     issue_mask,
  input  logic                             retire_valid,
  input  logic [WARP_ID_BITS-1:0]          retire_warp,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] retire_pc,
  input  logic [THREADS_PER_BLOCK-1:0]     retire_mask,
  input  logic                             retire_done,
  output logic                             busy,
  output logic                             all_done,
  output logic                             protocol_error
);

  warp_state_t                      r_state    [NUM_WARPS];
  warp_state_t                      w_state_nxt[NUM_WARPS];
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_pc       [NUM_WARPS];
  logic [PROGRAM_MEM_ADDR_BITS-1:0] w_pc_nxt   [NUM_WARPS];
  logic [THREADS_PER_BLOCK-1:0]     r_mask     [NUM_WARPS];
  logic [THREADS_PER_BLOCK-1:0]     w_mask_nxt [NUM_WARPS];

  logic [WARP_ID_BITS-1:0]          r_ptr, w_ptr_nxt;
  logic                             r_slot_valid, w_slot_valid_nxt;
  logic [WARP_ID_BITS-1:0]          r_slot_warp, w_slot_warp_nxt;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_slot_pc, w_slot_pc_nxt;
  logic [THREADS_PER_BLOCK-1:0]     r_slot_mask, w_slot_mask_nxt;
  logic                             r_protocol_error, w_protocol_error_nxt;

  logic [NUM_WARPS-1:0]             w_req;
  logic [NUM_WARPS-1:0]             w_grant;
  logic                             w_grant_valid;
  logic [WARP_ID_BITS-1:0]          w_grant_id;
  logic                             w_busy;
  logic                             w_all_done;
  logic                             w_start_acc;
  logic                             w_handshake;
  logic                             w_load;
  logic                             w_retire_legal;
  logic                             w_retire_illegal;
  logic                             w_retire_to_done;

  // Eligibility comes from registered state only, so a warp retired this
  // cycle cannot win the slot until the following cycle.
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_req
    assign w_req[g] = (r_state[g] == READY);
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_WARPS),
    .PTR_BITS (WARP_ID_BITS)
  ) u_rr_arbiter (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .valid (w_grant_valid)
  );

  always_comb begin
    w_grant_id = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w_grant[i]) w_grant_id = WARP_ID_BITS'(i);
    end
  end

  always_comb begin
    w_busy     = 1'b0;
    w_all_done = 1'b1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (r_state[i] == READY || r_state[i] == SLOT || r_state[i] == INFLIGHT) w_busy = 1'b1;
      if (r_state[i] != DONE) w_all_done = 1'b0;
    end
  end

  assign w_start_acc      = start && !w_busy;
  assign w_handshake      = r_slot_valid && issue_ready;
  assign w_load           = !r_slot_valid || w_handshake;
  assign w_retire_legal   = retire_valid && (r_state[retire_warp] == INFLIGHT);
  assign w_retire_illegal = retire_valid && !w_retire_legal;
  assign w_retire_to_done = retire_done || (retire_mask == '0);

  always_comb begin
    w_state_nxt          = r_state;
    w_pc_nxt             = r_pc;
    w_mask_nxt           = r_mask;
    w_ptr_nxt            = r_ptr;
    w_slot_valid_nxt     = r_slot_valid;
    w_slot_warp_nxt      = r_slot_warp;
    w_slot_pc_nxt        = r_slot_pc;
    w_slot_mask_nxt      = r_slot_mask;
    w_protocol_error_nxt = r_protocol_error;

    if (w_start_acc) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        w_state_nxt[i] = READY;
        w_pc_nxt[i]    = '0;
        w_mask_nxt[i]  = '1;
      end
      w_ptr_nxt            = '0;
      w_slot_valid_nxt     = 1'b0;
      w_slot_warp_nxt      = '0;
      w_slot_pc_nxt        = '0;
      w_slot_mask_nxt      = '0;
      w_protocol_error_nxt = 1'b0;
    end else begin
      // Handshake, slot winner and legal retire always hit distinct warps
      // because each requires a different current state.
      if (w_handshake) w_state_nxt[r_slot_warp] = INFLIGHT;

      if (w_load) begin
        if (w_grant_valid) begin
          w_state_nxt[w_grant_id] = SLOT;
          w_slot_valid_nxt        = 1'b1;
          w_slot_warp_nxt         = w_grant_id;
          w_slot_pc_nxt           = r_pc[w_grant_id];
          w_slot_mask_nxt         = r_mask[w_grant_id];
          w_ptr_nxt               = w_grant_id + WARP_ID_BITS'(1);
        end else begin
          w_slot_valid_nxt = 1'b0;
          w_slot_warp_nxt  = '0;
          w_slot_pc_nxt    = '0;
          w_slot_mask_nxt  = '0;
        end
      end

      if (w_retire_legal) begin
        w_pc_nxt[retire_warp]    = retire_pc;
        w_mask_nxt[retire_warp]  = retire_mask;
        w_state_nxt[retire_warp] = w_retire_to_done ? DONE : READY;
      end
    end

    if (w_retire_illegal) w_protocol_error_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        r_state[i] <= IDLE;
        r_pc[i]    <= '0;
        r_mask[i]  <= '0;
      end
      r_ptr            <= '0;
      r_slot_valid     <= 1'b0;
      r_slot_warp      <= '0;
      r_slot_pc        <= '0;
      r_slot_mask      <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_mask           <= w_mask_nxt;
      r_ptr            <= w_ptr_nxt;
      r_slot_valid     <= w_slot_valid_nxt;
      r_slot_warp      <= w_slot_warp_nxt;
      r_slot_pc        <= w_slot_pc_nxt;
      r_slot_mask      <= w_slot_mask_nxt;
      r_protocol_error <= w_protocol_error_nxt;
    end
  end

  assign issue_valid    = r_slot_valid;
  assign issue_warp     = r_slot_warp;
  assign issue_pc       = r_slot_pc;
  assign issue_mask     = r_slot_mask;
  assign busy           = w_busy;
  assign all_done       = w_all_done;
  assign protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_scheduler
// Brief    : Directed plus randomized bench with a behavioural warp model.
// Revision : 1.0
// ============================================================================
module tb_warp_scheduler;

  localparam int NW = 4;
  localparam int ST_IDLE = 0, ST_READY = 1, ST_SLOT = 2, ST_INFLIGHT = 3, ST_DONE = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       issue_valid;
  logic       issue_ready;
  logic [1:0] issue_warp;
  logic [7:0] issue_pc;
  logic [3:0] issue_mask;
  logic       retire_valid;
  logic [1:0] retire_warp;
  logic [7:0] retire_pc;
  logic [3:0] retire_mask;
  logic       retire_done;
  logic       busy;
  logic       all_done;
  logic       protocol_error;

  int checks = 0;
  int errors = 0;

  warp_scheduler #(
    .NUM_WARPS             (4),
    .PROGRAM_MEM_ADDR_BITS (8),
    .THREADS_PER_BLOCK     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_warp     (issue_warp),
    .issue_pc       (issue_pc),
    .issue_mask     (issue_mask),
    .retire_valid   (retire_valid),
    .retire_warp    (retire_warp),
    .retire_pc      (retire_pc),
    .retire_mask    (retire_mask),
    .retire_done    (retire_done),
    .busy           (busy),
    .all_done       (all_done),
    .protocol_error (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: current (m_) and next (n_) warp table plus slot.
  int         m_st[NW], n_st[NW];
  logic [7:0] m_pc[NW], n_pc[NW];
  logic [3:0] m_mask[NW], n_mask[NW];
  int         m_ptr, n_ptr, m_sw, n_sw;
  bit         m_sv, n_sv, m_pe, n_pe;
  logic [7:0] m_spc, n_spc;
  logic [3:0] m_smask, n_smask;
  int         inflight_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    for (int i = 0; i < NW; i++)
      if (m_st[i] == ST_READY || m_st[i] == ST_SLOT || m_st[i] == ST_INFLIGHT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_all_done();
    for (int i = 0; i < NW; i++)
      if (m_st[i] != ST_DONE) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_st[i] = ST_IDLE; m_pc[i] = '0; m_mask[i] = '0;
    end
    m_ptr = 0; m_sv = 0; m_sw = 0; m_spc = '0; m_smask = '0; m_pe = 0;
    n_st = m_st; n_pc = m_pc; n_mask = m_mask;
    n_ptr = 0; n_sv = 0; n_sw = 0; n_spc = '0; n_smask = '0; n_pe = 0;
  endtask

  task automatic model_commit();
    m_st = n_st; m_pc = n_pc; m_mask = n_mask;
    m_ptr = n_ptr; m_sv = n_sv; m_sw = n_sw; m_spc = n_spc; m_smask = n_smask; m_pe = n_pe;
  endtask

  // Next model state from the scheduling rules and the inputs of this cycle.
  task automatic model_eval();
    int  w;
    bit  found;
    int  rw;
    if (!reset) begin
      model_reset();
      return;
    end
    n_st = m_st; n_pc = m_pc; n_mask = m_mask;
    n_ptr = m_ptr; n_sv = m_sv; n_sw = m_sw; n_spc = m_spc; n_smask = m_smask; n_pe = m_pe;
    rw = int'(retire_warp);
    if (start && !model_busy()) begin
      for (int i = 0; i < NW; i++) begin
        n_st[i] = ST_READY; n_pc[i] = 8'h00; n_mask[i] = 4'hF;
      end
      n_ptr = 0; n_sv = 0; n_pe = 0;
    end else begin
      if (m_sv && issue_ready) n_st[m_sw] = ST_INFLIGHT;
      if (!m_sv || issue_ready) begin
        found = 0;
        for (int k = 0; k < NW; k++) begin
          w = (m_ptr + k) % NW;
          if (!found && m_st[w] == ST_READY) begin
            found = 1;
            n_st[w] = ST_SLOT;
            n_sv = 1; n_sw = w; n_spc = m_pc[w]; n_smask = m_mask[w];
            n_ptr = (w + 1) % NW;
          end
        end
        if (!found) n_sv = 0;
      end
      if (retire_valid && m_st[rw] == ST_INFLIGHT) begin
        n_pc[rw]   = retire_pc;
        n_mask[rw] = retire_mask;
        n_st[rw]   = (retire_done || retire_mask == 4'h0) ? ST_DONE : ST_READY;
      end
    end
    if (retire_valid && m_st[rw] != ST_INFLIGHT) n_pe = 1;
  endtask

  // Compare process: outputs are sampled mid-cycle against the model.
  always @(negedge clk) begin
    chk("issue_valid", 32'(issue_valid), 32'(m_sv));
    if (m_sv) begin
      chk("issue_warp", 32'(issue_warp), 32'(m_sw));
      chk("issue_pc", 32'(issue_pc), 32'(m_spc));
      chk("issue_mask", 32'(issue_mask), 32'(m_smask));
    end
    chk("busy", 32'(busy), 32'(model_busy()));
    chk("all_done", 32'(all_done), 32'(model_all_done()));
    chk("protocol_error", 32'(protocol_error), 32'(m_pe));
  end

  task automatic cyc(input bit rn, input bit st, input bit rdy, input bit rv,
                     input int rw, input int rpc, input int rmask, input bit rd);
    @(posedge clk);
    model_commit();
    #1;
    reset        = rn;
    start        = st;
    issue_ready  = rdy;
    retire_valid = rv;
    retire_warp  = 2'(rw);
    retire_pc    = 8'(rpc);
    retire_mask  = 4'(rmask);
    retire_done  = rd;
    model_eval();
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cyc(1, 0, rdy, 0, 0, 0, 0, 0);
  endtask

  task automatic ret(input bit rdy, input int w, input int pc, input int mask, input bit done);
    cyc(1, 0, rdy, 1, w, pc, mask, done);
  endtask

  task automatic slot_is(input string tag, input int w, input int pc, input int mask);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, "_warp"}, 32'(issue_warp), 32'(w));
    chk({tag, "_pc"}, 32'(issue_pc), 32'(pc));
    chk({tag, "_mask"}, 32'(issue_mask), 32'(mask));
  endtask

  initial begin
    reset = 0; start = 0; issue_ready = 0; retire_valid = 0;
    retire_warp = 0; retire_pc = 0; retire_mask = 0; retire_done = 0;
    model_reset();

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_warp", 32'(issue_warp), 32'd0);
    chk("rst_pc", 32'(issue_pc), 32'd0);
    chk("rst_mask", 32'(issue_mask), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_all_done", 32'(all_done), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);

    // Launch: warps 0..3 issue back-to-back from cycle 2.
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("lat_c1_valid", 32'(issue_valid), 32'd0);
    chk("lat_c1_busy", 32'(busy), 32'd1);
    idle(1); slot_is("seq0", 0, 8'h00, 4'hF);
    idle(1); slot_is("seq1", 1, 8'h00, 4'hF);
    idle(1); slot_is("seq2", 2, 8'h00, 4'hF);
    idle(1); slot_is("seq3", 3, 8'h00, 4'hF);

    // Retire 3, 0, 2 in turn; reissue order follows the pointer.
    ret(1, 3, 8'h30, 4'hF, 0);
    chk("c6_valid", 32'(issue_valid), 32'd0);
    ret(1, 0, 8'h40, 4'hF, 0);
    ret(1, 2, 8'h12, 4'h5, 0);
    slot_is("reis3", 3, 8'h30, 4'hF);
    idle(1); slot_is("reis0", 0, 8'h40, 4'hF);
    idle(1); slot_is("reis2", 2, 8'h12, 4'h5);

    // Completion, including a zero-mask retire without RET.
    ret(1, 1, 8'h00, 4'hF, 1);
    ret(1, 3, 8'h00, 4'hF, 1);
    ret(1, 0, 8'h00, 4'hF, 1);
    ret(1, 2, 8'h00, 4'h0, 0);
    chk("c14_all_done", 32'(all_done), 32'd0);
    chk("c14_busy", 32'(busy), 32'd1);

    // Relaunch, then backpressure with warp 1 parked in the slot.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("c15_all_done", 32'(all_done), 32'd1);
    chk("c15_busy", 32'(busy), 32'd0);
    idle(0);
    idle(1); slot_is("bp_w0", 0, 8'h00, 4'hF);
    idle(0); slot_is("bp_hold0", 1, 8'h00, 4'hF);
    ret(0, 0, 8'h55, 4'hF, 0); slot_is("bp_hold1", 1, 8'h00, 4'hF);
    for (int i = 0; i < 3; i++) begin
      idle(0); slot_is("bp_holdn", 1, 8'h00, 4'hF);
    end
    idle(1); slot_is("bp_release", 1, 8'h00, 4'hF);
    idle(1); slot_is("bp_next2", 2, 8'h00, 4'hF);

    // Illegal retire of warp 3 while it sits in the slot; start while busy.
    ret(0, 3, 8'hAA, 4'h3, 0); slot_is("ill_slot3", 3, 8'h00, 4'hF);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("ill_perr", 32'(protocol_error), 32'd1);
    slot_is("ill_unchanged", 3, 8'h00, 4'hF);
    idle(1);
    chk("busy_start_ignored", 32'(protocol_error), 32'd1);
    slot_is("busy_start_slot", 3, 8'h00, 4'hF);
    idle(1); slot_is("after_ill_w0", 0, 8'h55, 4'hF);
    ret(1, 0, 0, 4'hF, 1);
    ret(1, 1, 0, 4'hF, 1);
    ret(1, 2, 0, 4'hF, 1);
    ret(1, 3, 0, 4'hF, 1);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    chk("done_perr_held", 32'(protocol_error), 32'd1);
    chk("done_all", 32'(all_done), 32'd1);
    idle(1);
    chk("start_clears_perr", 32'(protocol_error), 32'd0);

    // Reset with warps in flight, then a stale retire.
    idle(1); idle(1); idle(1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("midrst_valid", 32'(issue_valid), 32'd0);
    chk("midrst_warp", 32'(issue_warp), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_perr", 32'(protocol_error), 32'd0);
    ret(1, 0, 8'h10, 4'hF, 0);
    idle(1);
    chk("stale_retire_perr", 32'(protocol_error), 32'd1);

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      bit rn, st, rdy, rv, rd;
      int rw, rmask;
      inflight_q.delete();
      for (int i = 0; i < NW; i++) if (m_st[i] == ST_INFLIGHT) inflight_q.push_back(i);
      rn  = ($urandom_range(0, 399) != 0);
      st  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = 0; rw = 0;
      if (inflight_q.size() > 0 && $urandom_range(0, 9) < 6) begin
        rv = 1; rw = inflight_q[$urandom_range(0, inflight_q.size() - 1)];
      end else if ($urandom_range(0, 29) == 0) begin
        rv = 1; rw = $urandom_range(0, NW - 1);
      end
      rmask = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
      rd    = ($urandom_range(0, 9) == 0);
      cyc(rn, st, rdy, rv, rw, $urandom_range(0, 255), rmask, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
